muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional signed support is enabled by defining MULDIV_SIGNED_EN.
`timescale 1ns/1ps
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic [2:0]       flag
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic [2:0]       flag_q, flag_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             sgn_op, neg_res, neg_rem;

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic sgn_q, nres_q, nrem_q;

    assign a_neg = op[1] & data_a[WIDTH-1];
    assign b_neg = op[1] & data_b[WIDTH-1];
    assign a_mag = a_neg ? -data_a : data_a;
    assign b_mag = b_neg ? -data_b : data_b;

    // Sign fix-up bits are captured with the operands and applied when results are latched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sgn_q  <= 1'b0;
            nres_q <= 1'b0;
            nrem_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            sgn_q  <= op[1];
            nres_q <= a_neg ^ b_neg;
            nrem_q <= a_neg;
        end
    end

    assign sgn_op  = sgn_q;
    assign neg_res = nres_q;
    assign neg_rem = nrem_q;
`else
    logic unused_op1;
    assign unused_op1 = op[1];
    assign a_mag   = data_a;
    assign b_mag   = data_b;
    assign sgn_op  = 1'b0;
    assign neg_res = 1'b0;
    assign neg_rem = 1'b0;
`endif

    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [WIDTH-1:0]   it_hi, it_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem, fin_hi, fin_lo;
    logic               fin_zero, fin_ovf;

    // One iteration: multiply adds the multiplicand on the multiplier LSB then shifts right;
    // divide shifts the next dividend bit into the remainder and subtracts if it fits.
    assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign rem_sh = {hi_q, lo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign it_hi  = div_q ? (diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
    assign it_lo  = div_q ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};

    assign prod     = neg_res ? -{it_hi, it_lo} : {it_hi, it_lo};
    assign quot     = neg_res ? -it_lo : it_lo;
    assign rem      = neg_rem ? -it_hi : it_hi;
    assign fin_hi   = div_q ? rem  : prod[2*WIDTH-1:WIDTH];
    assign fin_lo   = div_q ? quot : prod[WIDTH-1:0];
    assign fin_zero = div_q ? (fin_lo == '0) : ({fin_hi, fin_lo} == '0);
    assign fin_ovf  = !div_q && (sgn_op ? (fin_hi != {WIDTH{fin_lo[WIDTH-1]}}) : (fin_hi != '0));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        div_d    = div_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        flag_d   = flag_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    div_d = op[0];
                    cnt_d = '0;
                    hi_d  = '0;
                    lo_d  = op[0] ? a_mag : b_mag;
                    b_d   = op[0] ? b_mag : a_mag;
                    if (op[0] && data_b == '0) begin
                        state_d  = DONE;
                        res_hi_d = data_a;
                        res_lo_d = '1;
                        flag_d   = 3'b010;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                hi_d  = it_hi;
                lo_d  = it_lo;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d  = DONE;
                    res_hi_d = fin_hi;
                    res_lo_d = fin_lo;
                    flag_d   = {fin_ovf, 1'b0, fin_zero};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            flag_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            div_q    <= div_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            flag_q   <= flag_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign flag      = flag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (WIDTH=32); the op[1] scenario adapts to MULDIV_SIGNED_EN.
`timescale 1ns/1ps
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] data_a = '0;
    logic [31:0] data_b = '0;
    logic        busy, done;
    logic [31:0] result_hi, result_lo;
    logic [2:0]  flag;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .data_a(data_a), .data_b(data_b), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .flag(flag)
    );

    always #5 clock = ~clock;

    // Counts cycles from the accepting edge (1 = first cycle after it) until done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                          output int cyc);
        @(negedge clock);
        data_a = a; data_b = b; op = o; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc);
    endtask

    task automatic test_reset;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({result_hi, result_lo} !== 64'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", {result_hi, result_lo}); end
        checks++; if (flag !== 3'b000) begin errors++; $display("FAIL reset_flag got=%b exp=000", flag); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_mul_unsigned;
        int cyc;
        run_op(32'hFFFF_FFFF, 32'd2, 2'b00, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_latency got=%0d exp=33", cyc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_in_done got=%b exp=1", busy); end
        checks++; if (result_hi !== 32'h1) begin errors++; $display("FAIL mul_hi got=%h exp=1", result_hi); end
        checks++; if (result_lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_lo got=%h exp=fffffffe", result_lo); end
        checks++; if (flag !== 3'b100) begin errors++; $display("FAIL mul_flag got=%b exp=100", flag); end
        @(negedge clock);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got done=%b busy=%b exp 0 0", done, busy); end
    endtask

    task automatic test_div_unsigned;
        int cyc;
        run_op(32'd100, 32'd7, 2'b01, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL div_latency got=%0d exp=33", cyc); end
        checks++; if (result_lo !== 32'd14) begin errors++; $display("FAIL div_quot got=%0d exp=14", result_lo); end
        checks++; if (result_hi !== 32'd2) begin errors++; $display("FAIL div_rem got=%0d exp=2", result_hi); end
        checks++; if (flag !== 3'b000) begin errors++; $display("FAIL div_flag got=%b exp=000", flag); end
    endtask

    task automatic test_div_by_zero;
        int cyc;
        run_op(32'h1234, 32'd0, 2'b01, cyc);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL dbz_latency got=%0d exp=1", cyc); end
        checks++; if (result_lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo got=%h exp=ffffffff", result_lo); end
        checks++; if (result_hi !== 32'h1234) begin errors++; $display("FAIL dbz_hi got=%h exp=1234", result_hi); end
        checks++; if (flag !== 3'b010) begin errors++; $display("FAIL dbz_flag got=%b exp=010", flag); end
    endtask

    task automatic test_zero_flags;
        int cyc;
        run_op(32'h0001_2345, 32'd0, 2'b00, cyc);
        checks++; if ({result_hi, result_lo} !== 64'h0) begin errors++; $display("FAIL mulzero_result got=%h exp=0", {result_hi, result_lo}); end
        checks++; if (flag !== 3'b001) begin errors++; $display("FAIL mulzero_flag got=%b exp=001", flag); end
        run_op(32'd3, 32'd7, 2'b01, cyc);
        checks++; if (result_lo !== 32'd0 || result_hi !== 32'd3) begin errors++; $display("FAIL divsmall_result got q=%0d r=%0d exp q=0 r=3", result_lo, result_hi); end
        checks++; if (flag !== 3'b001) begin errors++; $display("FAIL divsmall_flag got=%b exp=001", flag); end
        run_op(32'h0001_0000, 32'h0001_0000, 2'b00, cyc);
        checks++; if (result_hi !== 32'h1 || result_lo !== 32'h0) begin errors++; $display("FAIL mul2p32_result got=%h_%h exp=00000001_00000000", result_hi, result_lo); end
        checks++; if (flag !== 3'b100) begin errors++; $display("FAIL mul2p32_flag got=%b exp=100", flag); end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        @(negedge clock);
        data_a = 32'd6; data_b = 32'd7; op = 2'b00; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (cyc == 5) begin
                data_a = 32'd9; data_b = 32'd9; op = 2'b01; start = 1'b1;
            end else if (cyc == 6) begin
                start = 1'b0; data_a = 32'd1000;
            end
        end
        checks++; if (cyc !== 33) begin errors++; $display("FAIL busy_latency got=%0d exp=33", cyc); end
        checks++; if (result_lo !== 32'd42 || result_hi !== 32'd0) begin errors++; $display("FAIL busy_result got=%h_%h exp=0_2a", result_hi, result_lo); end
        checks++; if (flag !== 3'b000) begin errors++; $display("FAIL busy_flag got=%b exp=000", flag); end
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_no_restart got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        run_op(32'd3, 32'd4, 2'b00, cyc);
        checks++; if (result_lo !== 32'd12) begin errors++; $display("FAIL b2b_first got=%0d exp=12", result_lo); end
        run_op(32'd20, 32'd6, 2'b01, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", cyc); end
        checks++; if (result_lo !== 32'd3 || result_hi !== 32'd2) begin errors++; $display("FAIL b2b_second got q=%0d r=%0d exp q=3 r=2", result_lo, result_hi); end
    endtask

    task automatic test_op1;
        int cyc;
        run_op(32'hFFFF_FFF9, 32'd2, 2'b11, cyc);
`ifdef MULDIV_SIGNED_EN
        checks++; if (result_lo !== 32'hFFFF_FFFD || result_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sdiv_result got=%h_%h exp=ffffffff_fffffffd", result_hi, result_lo); end
        checks++; if (flag !== 3'b000) begin errors++; $display("FAIL sdiv_flag got=%b exp=000", flag); end
`else
        checks++; if (result_lo !== 32'h7FFF_FFFC || result_hi !== 32'd1) begin errors++; $display("FAIL udiv_op1_result got=%h_%h exp=00000001_7ffffffc", result_hi, result_lo); end
        checks++; if (flag !== 3'b000) begin errors++; $display("FAIL udiv_op1_flag got=%b exp=000", flag); end
`endif
        checks++; if (cyc !== 33) begin errors++; $display("FAIL op1_latency got=%0d exp=33", cyc); end
        run_op(32'hFFFF_FFF9, 32'd2, 2'b10, cyc);
`ifdef MULDIV_SIGNED_EN
        checks++; if (result_hi !== 32'hFFFF_FFFF || result_lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL smul_result got=%h_%h exp=ffffffff_fffffff2", result_hi, result_lo); end
        checks++; if (flag !== 3'b000) begin errors++; $display("FAIL smul_flag got=%b exp=000", flag); end
`else
        checks++; if (result_hi !== 32'd1 || result_lo !== 32'hFFFF_FFF2) begin errors++; $display("FAIL umul_op1_result got=%h_%h exp=00000001_fffffff2", result_hi, result_lo); end
        checks++; if (flag !== 3'b100) begin errors++; $display("FAIL umul_op1_flag got=%b exp=100", flag); end
`endif
    endtask

    task automatic test_reset_mid_calc;
        int seen;
        @(negedge clock);
        data_a = 32'd5; data_b = 32'd7; op = 2'b00; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b exp 0 0", busy, done); end
        checks++; if ({result_hi, result_lo} !== 64'h0) begin errors++; $display("FAIL midrst_result got=%h exp=0", {result_hi, result_lo}); end
        checks++; if (flag !== 3'b000) begin errors++; $display("FAIL midrst_flag got=%b exp=000", flag); end
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d active cycles exp=0", seen); end
    endtask

    task automatic test_reset_release;
        int cyc;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        data_a = 32'd5; data_b = 32'd7; op = 2'b00; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        wait_done(cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL rstrel_latency got=%0d exp=33", cyc); end
        checks++; if (result_lo !== 32'd35 || result_hi !== 32'd0 || flag !== 3'b000) begin errors++; $display("FAIL rstrel_result got=%h_%h flag=%b exp=0_23 flag=000", result_hi, result_lo, flag); end
    endtask

    initial begin
        test_reset();
        test_mul_unsigned();
        test_div_unsigned();
        test_div_by_zero();
        test_zero_flags();
        test_start_while_busy();
        test_back_to_back();
        test_op1();
        test_reset_mid_calc();
        test_reset_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
